// File: rtl/gf180mcu_osu_sc_gp9t3v3__chain_ctrl_if.sv
// Bus between the scan-chain sequencer and its requester/chain.
// Handshake: a request is taken when start=1 while busy=0 and the sequencer is idle;
// completion is the one-cycle done pulse, a reserved op returns a one-cycle err pulse instead.
interface gf180mcu_osu_sc_gp9t3v3__chain_ctrl_if #(
  parameter int LEN = 8
);
  logic           start;
  logic [1:0]     op;
  logic [LEN-1:0] din;
  logic           chain_q;
  logic           chain_d;
  logic           se;
  logic           ce;
  logic [LEN-1:0] dout;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     dbg_state;

  modport slave (
    input  start, op, din, chain_q,
    output chain_d, se, ce, dout, busy, done, err, dbg_state
  );

  modport master (
    output start, op, din, chain_q,
    input  chain_d, se, ce, dout, busy, done, err, dbg_state
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3__chain_ctrl.sv
// Sequencer for a LEN-flop serial register chain: shift load/unload and functional capture.
// Every output is a flop computed from the next state, so outputs line up with the state they describe.
module gf180mcu_osu_sc_gp9t3v3__chain_ctrl #(
  parameter int LEN = 8,
  parameter int CW  = 8
) (
  input  logic clk,
  input  logic rn,
  gf180mcu_osu_sc_gp9t3v3__chain_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [1:0] OP_SHIFT      = 2'b00;
  localparam logic [1:0] OP_CAPT       = 2'b01;
  localparam logic [1:0] OP_SHIFT_CAPT = 2'b10;
  localparam logic [CW-1:0] CNT_LAST   = CW'(LEN - 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [LEN-1:0] shadow, shadow_n;
  logic [LEN-1:0] dout_r, dout_n;
  logic [1:0]     op_q, op_n;
  logic           se_r, se_n;
  logic           ce_r, ce_n;
  logic           chain_d_r, chain_d_n;
  logic           busy_r, busy_n;
  logic           done_r, done_n;
  logic           err_r, err_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    dout_n   = dout_r;
    op_n     = op_q;
    err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          shadow_n = bus.din;
          op_n     = bus.op;
          case (bus.op)
            OP_SHIFT, OP_SHIFT_CAPT: state_n = SHIFT;
            OP_CAPT:                 state_n = CAPT;
            default:                 err_n   = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        // chain_q still holds the bit for this cycle; the chain advances on this same edge
        for (int i = 0; i < LEN; i++) begin
          if (cnt == CW'(i)) dout_n[i] = bus.chain_q;
        end
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = (op_q == OP_SHIFT_CAPT) ? CAPT : FIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CAPT:    state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n    = (state_n != IDLE);
    se_n      = (state_n == SHIFT);
    ce_n      = (state_n == SHIFT) || (state_n == CAPT);
    done_n    = (state_n == FIN);
    chain_d_n = 1'b0;
    if (state_n == SHIFT) begin
      for (int i = 0; i < LEN; i++) begin
        if (cnt_n == CW'(i)) chain_d_n = shadow_n[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      dout_r    <= '0;
      op_q      <= '0;
      se_r      <= 1'b0;
      ce_r      <= 1'b0;
      chain_d_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shadow    <= shadow_n;
      dout_r    <= dout_n;
      op_q      <= op_n;
      se_r      <= se_n;
      ce_r      <= ce_n;
      chain_d_r <= chain_d_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      err_r     <= err_n;
    end
  end

  assign bus.se        = se_r;
  assign bus.ce        = ce_r;
  assign bus.chain_d   = chain_d_r;
  assign bus.dout      = dout_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__chain_ctrl.sv
// Bench for the chain sequencer: behavioural 8-flop chain, scoreboard of expected {chain, dout} per op.
module tb_gf180mcu_osu_sc_gp9t3v3__chain_ctrl;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rn;

  gf180mcu_osu_sc_gp9t3v3__chain_ctrl_if #(.LEN(LEN)) bus ();

  gf180mcu_osu_sc_gp9t3v3__chain_ctrl #(.LEN(LEN), .CW(8)) dut (
    .clk (clk),
    .rn  (rn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // chain model: gated by ce, shifts toward chain_q when se=1, otherwise loads functional inputs
  logic [LEN-1:0] chain, func_in, preload_val;
  logic           preload_en;
  always @(posedge clk) begin
    if (preload_en) chain <= preload_val;
    else if (bus.ce) chain <= bus.se ? {bus.chain_d, chain[LEN-1:1]} : func_in;
  end
  assign bus.chain_q = chain[0];

  int errors = 0;
  int checks = 0;
  logic [2*LEN-1:0] exp_q[$];
  logic [LEN-1:0]   m_chain, m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : sb_mon
    logic [2*LEN-1:0] e;
    if (rn === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_dout", 32'(bus.dout), 32'(e[LEN-1:0]));
        check("sb_chain", 32'(chain), 32'(e[2*LEN-1:LEN]));
      end
    end
  end

  task automatic push_expected(input logic [1:0] o, input logic [LEN-1:0] d, input logic [LEN-1:0] f);
    case (o)
      2'b00: begin exp_q.push_back({d, m_chain}); m_dout = m_chain; m_chain = d; end
      2'b01: begin exp_q.push_back({f, m_dout}); m_chain = f; end
      2'b10: begin exp_q.push_back({f, m_chain}); m_dout = m_chain; m_chain = f; end
      default: ;
    endcase
  endtask

  task automatic preload(input logic [LEN-1:0] v);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_val = v;
    @(negedge clk);
    preload_en = 1'b0;
    m_chain    = v;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [LEN-1:0] d, input logic [LEN-1:0] f,
                        output int lat, output int busy_cnt, output int se_cnt,
                        output int capt_cnt, output logic [LEN-1:0] d_seq);
    lat = 0; busy_cnt = 0; se_cnt = 0; capt_cnt = 0; d_seq = '0;
    @(negedge clk);
    func_in   = f;
    bus.op    = o;
    bus.din   = d;
    bus.start = 1'b1;
    push_expected(o, d, f);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.se && bus.ce) begin
        if (se_cnt < LEN) d_seq[se_cnt] = bus.chain_d;
        se_cnt++;
      end
      if (bus.ce && !bus.se) capt_cnt++;
      if (c == 1) begin
        bus.start = 1'b0;
        bus.din   = LEN'($urandom_range(0, 255));
      end
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_se"}, 32'(bus.se), 32'd0);
    check({tag, "_ce"}, 32'(bus.ce), 32'd0);
    check({tag, "_chain_d"}, 32'(bus.chain_d), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, sc, cc;
    logic [LEN-1:0] dseq, d, f, p;
    logic [1:0] o;

    rn = 1'b0; bus.start = 1'b0; bus.op = 2'b00; bus.din = '0;
    preload_en = 1'b0; preload_val = '0; func_in = '0;
    m_chain = '0; m_dout = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_dout", 32'(bus.dout), 32'd0);
    rn = 1'b1;

    // shift load/unload
    preload(8'hA5);
    run_op(2'b00, 8'h3C, 8'h00, lat, bc, sc, cc, dseq);
    check("shift_lat", lat, 9);
    check("shift_busy", bc, 9);
    check("shift_se_cycles", sc, 8);
    check("shift_chain_d_seq", 32'(dseq), 32'h3C);
    @(negedge clk);
    check_idle_outputs("after_shift");

    // capture only
    run_op(2'b01, 8'h00, 8'h5A, lat, bc, sc, cc, dseq);
    check("capt_lat", lat, 2);
    check("capt_ce_cycles", cc, 1);
    check("capt_se_cycles", sc, 0);

    // shift then capture
    preload(8'h81);
    run_op(2'b10, 8'hFF, 8'h00, lat, bc, sc, cc, dseq);
    check("sc_lat", lat, 10);
    check("sc_se_cycles", sc, 8);
    check("sc_ce_cycles", cc, 1);
    check("sc_busy", bc, 10);

    // reserved op
    @(negedge clk);
    bus.op = 2'b11; bus.din = 8'h11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rsvd_err", 32'(bus.err), 32'd1);
    check("rsvd_busy", 32'(bus.busy), 32'd0);
    check("rsvd_se", 32'(bus.se), 32'd0);
    check("rsvd_ce", 32'(bus.ce), 32'd0);
    check("rsvd_dout", 32'(bus.dout), 32'(m_dout));
    @(negedge clk);
    check("rsvd_err_pulse", 32'(bus.err), 32'd0);

    // start held high: back-to-back ops with one idle cycle between
    d = 8'hC3;
    bus.op = 2'b00; bus.din = d; bus.start = 1'b1;
    push_expected(2'b00, d, 8'h00);
    push_expected(2'b00, d, 8'h00);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("b2b_busy", 32'(bus.busy), ((c % 10) != 0) ? 32'd1 : 32'd0);
      check("b2b_done", 32'(bus.done), ((c % 10) == 9) ? 32'd1 : 32'd0);
      if (c == 20) bus.start = 1'b0;
    end

    // reset during shift cycle 4
    @(negedge clk);
    bus.op = 2'b00; bus.din = 8'h96; bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    rn = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_dout", 32'(bus.dout), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    check("start_in_reset_busy", 32'(bus.busy), 32'd0);
    rn = 1'b1; bus.start = 1'b0;
    m_dout = '0;
    @(negedge clk);
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    preload(8'h4E);
    run_op(2'b00, 8'h2B, 8'h00, lat, bc, sc, cc, dseq);
    check("post_abort_lat", lat, 9);
    check("post_abort_chain_d_seq", 32'(dseq), 32'h2B);

    // random ops
    for (int n = 0; n < 6; n++) begin
      o = 2'($urandom_range(0, 2));
      d = LEN'($urandom_range(0, 255));
      f = LEN'($urandom_range(0, 255));
      p = LEN'($urandom_range(0, 255));
      preload(p);
      run_op(o, d, f, lat, bc, sc, cc, dseq);
      check("rnd_lat", lat, (o == 2'b00) ? 9 : (o == 2'b01) ? 2 : 10);
      if (o != 2'b01) check("rnd_chain_d_seq", 32'(dseq), 32'(d));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
